// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one register-file port between two requesters; reply 2 cycles after accept (1 for a bad address).
// req_ready is low outside IDLE; a response is held until its requester asserts rsp_ready.
module reg_port_arbiter #(
  parameter int ENTRIES    = 12,
  parameter int ADDR_WIDTH = $clog2(ENTRIES),
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    system_reg_en,
  output logic                    system_reg_we,
  output logic [ADDR_WIDTH-1:0]   system_reg_addr,
  output logic [DATA_WIDTH-1:0]   system_reg_din,
  input  logic [DATA_WIDTH-1:0]   system_reg_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  localparam logic [ADDR_WIDTH:0] ENTRIES_W = (ADDR_WIDTH+1)'(ENTRIES);

  state_t state;
  logic   last_grant;
  logic   winner;
  logic   grant;
  cmd_t   sel_cmd;
  logic   sel_in_range;

  // Lone requester wins; on a tie the one not served last time wins.
  always_comb begin
    grant = ~last_grant;
    if (req_valid == 2'b01) begin
      grant = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    sel_cmd = grant ? {req_we[1], req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH], req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]}
                    : {req_we[0], req_addr[ADDR_WIDTH-1:0], req_wdata[DATA_WIDTH-1:0]};
    sel_in_range = ({1'b0, sel_cmd.addr} < ENTRIES_W);
  end

  // Gated by rst_n so no handshake can be seen while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && rst_n) begin
      req_ready = grant ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      winner          <= 1'b0;
      rsp_valid       <= 2'b00;
      rsp_err         <= 1'b0;
      rsp_rdata       <= '0;
      system_reg_en   <= 1'b0;
      system_reg_we   <= 1'b0;
      system_reg_addr <= '0;
      system_reg_din  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            last_grant <= grant;
            winner     <= grant;
            if (sel_in_range) begin
              state           <= ACCESS;
              system_reg_en   <= 1'b1;
              system_reg_we   <= sel_cmd.we;
              system_reg_addr <= sel_cmd.addr;
              system_reg_din  <= sel_cmd.wdata;
            end else begin
              state     <= RESP;
              rsp_valid <= grant ? 2'b10 : 2'b01;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          state         <= RESP;
          system_reg_en <= 1'b0;
          system_reg_we <= 1'b0;
          rsp_valid     <= winner ? 2'b10 : 2'b01;
          rsp_err       <= 1'b0;
          rsp_rdata     <= system_reg_we ? '0 : system_reg_dout;
        end
        RESP: begin
          if (rsp_ready[winner]) begin
            state     <= IDLE;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: behavioural 12-entry register file on the system port, scoreboard of expected responses.
`timescale 1ns/1ps
module tb_reg_port_arbiter;
  localparam int ENTRIES = 12;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [1:0]    req_we = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = 2'b00;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          system_reg_en;
  logic          system_reg_we;
  logic [AW-1:0] system_reg_addr;
  logic [DW-1:0] system_reg_din;
  logic [DW-1:0] system_reg_dout;

  typedef struct packed {
    logic [1:0]    v;
    logic          err;
    logic [DW-1:0] rdata;
    logic [31:0]   cyc;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] model [ENTRIES] = '{default: '0};
  logic [DW-1:0] rf    [ENTRIES] = '{default: '0};
  logic [31:0]   cyc = 0;
  int            en_count = 0;
  logic [31:0]   en_last = 0;
  int            rsp_seen = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  reg_port_arbiter #(.ENTRIES(ENTRIES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .system_reg_en(system_reg_en), .system_reg_we(system_reg_we),
    .system_reg_addr(system_reg_addr), .system_reg_din(system_reg_din),
    .system_reg_dout(system_reg_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (system_reg_en && system_reg_we && system_reg_addr < ENTRIES) rf[system_reg_addr] <= system_reg_din;
  end

  assign system_reg_dout = (system_reg_addr < ENTRIES) ? rf[system_reg_addr] : '0;

  always @(negedge clk) begin
    if (system_reg_en) begin
      en_count++;
      en_last = cyc;
    end
    if (|rsp_valid) rsp_seen++;
  end

  function automatic void expect_cmd(input logic i, input logic we, input logic [AW-1:0] a,
                                     input logic [DW-1:0] wd, input logic [31:0] acc);
    rsp_t e;
    e.v     = i ? 2'b10 : 2'b01;
    e.err   = (a >= ENTRIES);
    e.rdata = (e.err || we) ? '0 : model[a];
    e.cyc   = acc + (e.err ? 32'd1 : 32'd2);
    if (!e.err && we) model[a] = wd;
    sb.push_back(e);
  endfunction

  task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       output logic [31:0] acc);
    bit got = 0;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    acc = cyc;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout req%0d: req_ready never rose, required 1", i);
    end else begin
      expect_cmd(i[0], we, a, wd, acc);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output bit seen);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = |rsp_valid;
    end
  endtask

  task automatic test_reset;
    rsp_t r;
    req_valid = 2'b11;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    r = {rsp_valid, rsp_err, rsp_rdata, 32'd0};
    n_checks++;
    if ({r, system_reg_en, system_reg_we, system_reg_addr, system_reg_din} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rsp=%h en=%b we=%b addr=%h din=%h exp all 0",
               r, system_reg_en, system_reg_we, system_reg_addr, system_reg_din);
    end
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fairness;
    int ng = 0, nr = 0;
    logic g;
    logic [31:0] last_acc = 0;
    rsp_t r, e;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    req_we = 2'b01;
    req_addr = {4'd3, 4'd3};
    req_wdata = {32'h0, 32'h111};
    req_valid = 2'b11;
    for (int k = 0; k < 40 && (ng < 4 || nr < 4); k++) begin
      @(negedge clk);
      if (|rsp_valid) begin
        nr++;
        r = {rsp_valid, rsp_err, rsp_rdata, cyc};
        e = sb.pop_front();
        n_checks++;
        if (r !== e) begin n_fail++; $display("FAIL fair_rsp%0d got=%h exp=%h", nr, r, e); end
      end
      if (|req_ready) begin
        g = req_ready[1];
        n_checks++;
        if (g !== ng[0]) begin n_fail++; $display("FAIL fair_grant%0d got=%0d exp=%0d", ng, g, ng[0]); end
        if (ng > 0) begin
          n_checks++;
          if ((cyc - last_acc) !== 32'd3) begin
            n_fail++; $display("FAIL fair_spacing%0d got=%0d exp=3", ng, cyc - last_acc);
          end
        end
        expect_cmd(g, req_we[g], req_addr[g*AW +: AW], req_wdata[g*DW +: DW], cyc);
        last_acc = cyc;
        ng++;
        @(posedge clk); #1;
        if (g == 1'b0) req_wdata[DW-1:0] = 32'h222;
        if (ng == 4) req_valid = 2'b00;
      end
    end
    if (ng < 4 || nr < 4) begin
      n_checks++; n_fail++;
      $display("FAIL fair_timeout got grants=%0d rsps=%0d exp 4/4", ng, nr);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single_read;
    logic [31:0] acc;
    int e0;
    bit seen;
    rsp_t r, e;
    rsp_ready = 2'b11;
    issue(1, 1'b1, 4'd0, 32'h0000_0BEE, acc);
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL sr_write_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL sr_write_rsp got=%h exp=%h", r, e); end
    end
    e0 = en_count;
    issue(0, 1'b0, 4'd0, 32'h0, acc);
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL sr_read_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL sr_read_rsp got=%h exp=%h", r, e); end
    end
    n_checks++;
    if (en_count - e0 !== 1) begin n_fail++; $display("FAIL sr_en_count got=%0d exp=1", en_count - e0); end
    n_checks++;
    if (en_last !== acc + 1) begin n_fail++; $display("FAIL sr_en_cycle got=%0d exp=%0d", en_last, acc + 1); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL sr_rsp_clear got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] acc;
    int e0;
    bit seen;
    rsp_t r, e;
    rsp_ready = 2'b11;
    e0 = en_count;
    issue(1, 1'b0, 4'd13, 32'h0, acc);
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL oor_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL oor_rsp got=%h exp=%h", r, e); end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (en_count !== e0) begin n_fail++; $display("FAIL oor_no_access got=%0d exp=%0d", en_count, e0); end
  endtask

  task automatic test_write_readback;
    logic [31:0] acc;
    bit seen;
    rsp_t r, e;
    rsp_ready = 2'b11;
    issue(0, 1'b1, 4'd11, 32'hFFFF_FFFF, acc);
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL wb_write_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL wb_write_rsp got=%h exp=%h", r, e); end
    end
    issue(1, 1'b0, 4'd11, 32'h0, acc);
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL wb_read_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL wb_read_rsp got=%h exp=%h", r, e); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] acc;
    bit seen;
    rsp_t r, e;
    rsp_ready = 2'b10;
    issue(0, 1'b0, 4'd11, 32'h0, acc);
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL bp_rsp got=%h exp=%h", r, e); end
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[2*AW-1:AW] = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_rdata, req_ready} !== {2'b01, 32'hFFFF_FFFF, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b exp v=01 d=ffffffff rdy=00", k, rsp_valid, rsp_rdata, req_ready);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req_ready} !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release got v=%b rdy=%b exp v=00 rdy=10", rsp_valid, req_ready);
    end
    expect_cmd(1'b1, 1'b0, 4'd0, 32'h0, cyc);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_req1_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL bp_req1_rsp got=%h exp=%h", r, e); end
    end
  endtask

  task automatic test_reset_in_access;
    logic [31:0] acc;
    int r0;
    bit seen;
    rsp_t r, e;
    rsp_ready = 2'b11;
    issue(0, 1'b0, 4'd5, 32'hDEAD_BEEF, acc);
    n_checks++;
    if (system_reg_en !== 1'b1) begin n_fail++; $display("FAIL ra_in_access got en=%b exp=1", system_reg_en); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, system_reg_en, system_reg_we, system_reg_addr, system_reg_din} !== '0) begin
      n_fail++;
      $display("FAIL ra_outputs got rdy=%b v=%b err=%b d=%h en=%b we=%b a=%h din=%h exp all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata, system_reg_en, system_reg_we, system_reg_addr, system_reg_din);
    end
    sb.delete();
    r0 = rsp_seen;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (rsp_seen !== r0) begin n_fail++; $display("FAIL ra_no_rsp got=%0d exp=%0d", rsp_seen - r0, 0); end
    @(posedge clk); #1;
    req_we = 2'b00; req_addr = {4'd0, 4'd0}; req_valid = 2'b11;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ra_first_grant got=%b exp=01", req_ready); end
    expect_cmd(1'b0, 1'b0, 4'd0, 32'h0, cyc);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ra_post_rsp timeout, required rsp_valid"); end
    else begin
      r = {rsp_valid, rsp_err, rsp_rdata, cyc}; e = sb.pop_front();
      if (r !== e) begin n_fail++; $display("FAIL ra_post_rsp got=%h exp=%h", r, e); end
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_out_of_range();
    test_write_readback();
    test_backpressure();
    test_reset_in_access();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
Shares the single system port of register_file (en/we/addr/din/dout) between two requesters, for example a host bus bridge (req 0) and an internal sequencer (req 1).
- Arbitrates round-robin.
- Drives one register-file access at a time.
- Returns read data or a write acknowledge on a per-requester response handshake.
- Rejects out-of-range addresses with an error response and no register-file access.

Parameters:
ENTRIES, 12, number of register-file entries
ADDR_WIDTH, $clog2(ENTRIES), address width
DATA_WIDTH, 32, data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester command valid (bit i = requester i)
req_ready  output  2  per-requester command accept
req_we  input  2  per-requester write enable (1 = write, 0 = read)
req_addr  input  2*ADDR_WIDTH  per-requester address, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  2*DATA_WIDTH  per-requester write data, slice i
rsp_valid  output  2  per-requester response valid
rsp_ready  input  2  per-requester response accept
rsp_err  output  1  response error flag (address >= ENTRIES); valid with rsp_valid
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
system_reg_en  output  1  register-file port enable
system_reg_we  output  1  register-file write enable
system_reg_addr  output  ADDR_WIDTH  register-file address
system_reg_din  output  DATA_WIDTH  register-file write data
system_reg_dout  input  DATA_WIDTH  register-file read data, combinational from addr

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - All outputs 0: req_ready, rsp_valid, rsp_err, rsp_rdata, system_reg_en/we/addr/din.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready is combinational and one-hot: bit i=1 iff requester i is the current grant and req_valid[i]=1.
  - Grant rule: if only one requester is valid, it wins. If both are valid, the requester != last_grant wins.
  - On handshake (cycle N), the command is latched and last_grant updated.
  - In-range address (< ENTRIES): go to ACCESS.
  - Out-of-range address: go directly to RESP with rsp_err=1, rsp_rdata=0; system_reg_en stays 0.
- ACCESS (cycle N+1, exactly one cycle):
  - system_reg_en=1; system_reg_we/addr/din come from the latched command.
  - On a read, system_reg_dout is captured into rsp_rdata at the end of the cycle. On a write, rsp_rdata=0.
  - Then go to RESP.
  - system_reg_en/we are 0 in every state other than ACCESS. addr/din hold their last values.
- RESP (from cycle N+2):
  - rsp_valid[winner]=1 only; rsp_err and rsp_rdata are stable until the handshake.
  - On rsp_valid&&rsp_ready for the winner, go to IDLE and clear rsp_valid the next cycle.
  - rsp_ready on the non-winning requester is ignored.
- Latency and throughput:
  - In-range command: response 2 cycles after acceptance.
  - Error command: response 1 cycle after acceptance.
  - Minimum 3 cycles per in-range access, since IDLE must be re-entered before the next grant.
  - No command is accepted outside IDLE (req_ready=0).
- A requester may deassert req_valid before acceptance; the arbiter holds no pending state for it.
- Reset mid-operation (asynchronous):
  - Returns to the reset state immediately and drops any in-flight response.
  - A write whose ACCESS cycle already saw a clock edge has completed in the register file. Otherwise it is not performed.

Test Plan:
- Single read: req 0 reads addr 0 after a req 1 write of 32'h00000BEE to addr 0. Required:
  - system_reg_en=1 exactly one cycle, at N+1.
  - rsp_valid[0] at N+2 with rsp_rdata=32'h00000BEE, rsp_err=0.
- Fairness: both requesters valid continuously, alternating reads and writes. Required:
  - Grants alternate 0,1,0,1 over 4 transactions, 0 first after reset.
  - One access per 3 cycles when rsp_ready is tied high.
- Out-of-range: req 1 reads addr 13 (ENTRIES=12). Required:
  - system_reg_en never asserted.
  - rsp_valid[1] at N+1 with rsp_err=1, rsp_rdata=0.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles after a read of 32'hFFFFFFFF. Required:
  - rsp_valid[0] and rsp_rdata stay stable.
  - req_ready stays 2'b00 even with req_valid[1]=1.
  - Req 1 is granted the cycle after the response handshake.
- Write then read back: write 32'hFFFFFFFF to addr 11, then read addr 11. Required:
  - The write response has rsp_rdata=0, rsp_err=0.
  - The read returns 32'hFFFFFFFF.
- Reset in ACCESS: assert rst_n low during the ACCESS cycle of a read. Required:
  - All outputs return to 0 without a clock edge.
  - No rsp_valid follows.
  - The first grant after reset goes to requester 0.
